pb_step_scheduler: RTL and testbench

- Per-timestep sequencer for the presynaptic spike buffer (24x24 spike window, 144 beats x 4 spikes).
- Runs the trace init once per run, then for each timestep:
  - prefetches 144 spike nibbles from an upstream ready/valid source into a local buffer;
  - replays them to the buffer back-to-back;
  - waits for the buffer's send phase, triggers the neuron stage, then steps the timestep counter.
- Sits between the input encoder and the preBuffer/synapse array; the top-level run control sees one start/done pair.

---
 rtl/snn_ctrl_pkg.sv | 32 +++
 rtl/pb_step_scheduler_if.sv | 30 +++
 rtl/pb_spike_stage.sv | 41 ++++
 rtl/pb_step_scheduler.sv | 146 ++++++++++++++
 tb/tb_pb_step_scheduler.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_ctrl_pkg.sv
// Shared definitions for the presynaptic spike-buffer step scheduler.
// State encoding, spike window geometry and the buffer command bundle.
package snn_ctrl_pkg;

  localparam int N_BEAT  = 144;
  localparam int SPK_NIB = 4;
  localparam int STEP_W  = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_W_INIT,
    S_FILL,
    S_KICK,
    S_REPLAY,
    S_W_PB,
    S_NRN,
    S_W_NRN,
    S_STDP,
    S_W_STDP,
    S_NEXT,
    S_DONE
  } sched_state_e;

  // One-cycle command pulses towards the preBuffer.
  typedef struct packed {
    logic init;
    logic b_run;
    logic stdp_run;
  } pb_cmd_t;

endpackage

// File: rtl/pb_step_scheduler_if.sv
// Spike source, preBuffer and neuron-stage handshakes of pb_step_scheduler.
// master is the scheduler side, slave the surrounding pipeline.
interface pb_step_scheduler_if;
  import snn_ctrl_pkg::*;

  logic [SPK_NIB-1:0] i_src_spike;
  logic               i_src_valid;
  logic               o_src_ready;
  logic               o_pb_init;
  logic               o_pb_b_run;
  logic               o_pb_stdp_run;
  logic [SPK_NIB-1:0] o_pb_spike;
  logic               o_pb_valid;
  logic               i_pb_done;
  logic               o_nrn_run;
  logic               i_nrn_done;

  modport master (
    input  i_src_spike, i_src_valid, i_pb_done, i_nrn_done,
    output o_src_ready, o_pb_init, o_pb_b_run, o_pb_stdp_run,
           o_pb_spike, o_pb_valid, o_nrn_run
  );

  modport slave (
    output i_src_spike, i_src_valid, i_pb_done, i_nrn_done,
    input  o_src_ready, o_pb_init, o_pb_b_run, o_pb_stdp_run,
           o_pb_spike, o_pb_valid, o_nrn_run
  );

endinterface

// File: rtl/pb_spike_stage.sv
// Local spike window store: written one nibble per accepted source beat,
// then read back sequentially for replay; owns the shared beat counter.
module pb_spike_stage
  import snn_ctrl_pkg::*;
#(
  parameter int DEPTH = N_BEAT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [SPK_NIB-1:0] wr_data,
  input  logic               rd_en,
  output logic [SPK_NIB-1:0] rd_data,
  output logic               last
);

  localparam int BEAT_W = $clog2(DEPTH);

  logic [SPK_NIB-1:0] mem [DEPTH];
  logic [BEAT_W-1:0]  beat;

  // Counter is held at zero outside FILL/REPLAY so each phase starts at beat 0.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      beat <= '0;
    end else if (wr_en || rd_en) begin
      beat <= beat + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[beat] <= wr_data;
    end
  end

  assign rd_data = mem[beat];
  assign last    = (beat == BEAT_W'(DEPTH - 1));

endmodule

// File: rtl/pb_step_scheduler.sv
// Per-timestep sequencer for the presynaptic spike buffer: init, fill, replay,
// neuron update, step. Optional STDP phase is built with PB_SCHED_STDP_EN.
module pb_step_scheduler #(
  parameter int N_BEAT = snn_ctrl_pkg::N_BEAT,
  parameter int STEP_W = snn_ctrl_pkg::STEP_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [STEP_W-1:0]   i_num_step,
  input  logic                i_learn,
  pb_step_scheduler_if.master bus,
  output logic                o_busy,
  output logic [STEP_W-1:0]   o_step,
  output logic                o_done
);
  import snn_ctrl_pkg::*;

  sched_state_e       state;
  sched_state_e       state_nxt;
  logic [STEP_W-1:0]  step;
  logic [STEP_W-1:0]  num_q;
  logic               last_step;
  pb_cmd_t            cmd;
  logic               src_ready;
  logic               pb_valid;
  logic               nrn_run;
  logic               wr_en;
  logic               rd_en;
  logic               stage_clr;
  logic               stage_last;
  logic [SPK_NIB-1:0] stage_data;

  assign last_step = (step == num_q - STEP_W'(1));

  // A zero step count runs a single timestep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      step  <= '0;
      num_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && i_start) begin
        num_q <= (i_num_step == '0) ? STEP_W'(1) : i_num_step;
      end
      if (state == S_NEXT) begin
        step <= last_step ? '0 : step + STEP_W'(1);
      end
    end
  end

`ifdef PB_SCHED_STDP_EN
  logic learn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      learn_q <= 1'b0;
    end else if (state == S_IDLE && i_start) begin
      learn_q <= i_learn;
    end
  end
`else
  logic unused_learn;
  assign unused_learn = i_learn;
`endif

  always_comb begin
    state_nxt = state;
    cmd       = '0;
    src_ready = 1'b0;
    pb_valid  = 1'b0;
    nrn_run   = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    case (state)
      S_IDLE:   if (i_start) state_nxt = S_INIT;
      S_INIT: begin
        cmd.init  = 1'b1;
        state_nxt = S_W_INIT;
      end
      S_W_INIT: if (bus.i_pb_done) state_nxt = S_FILL;
      S_FILL: begin
        src_ready = 1'b1;
        wr_en     = bus.i_src_valid;
        if (bus.i_src_valid && stage_last) state_nxt = S_KICK;
      end
      S_KICK: begin
        cmd.b_run = 1'b1;
        state_nxt = S_REPLAY;
      end
      // The buffer takes one beat per cycle, so replay never pauses.
      S_REPLAY: begin
        pb_valid = 1'b1;
        rd_en    = 1'b1;
        if (stage_last) state_nxt = S_W_PB;
      end
      S_W_PB:   if (bus.i_pb_done) state_nxt = S_NRN;
      S_NRN: begin
        nrn_run   = 1'b1;
        state_nxt = S_W_NRN;
      end
`ifdef PB_SCHED_STDP_EN
      S_W_NRN:  if (bus.i_nrn_done) state_nxt = learn_q ? S_STDP : S_NEXT;
      S_STDP: begin
        cmd.stdp_run = 1'b1;
        state_nxt    = S_W_STDP;
      end
      S_W_STDP: if (bus.i_pb_done) state_nxt = S_NEXT;
`else
      S_W_NRN:  if (bus.i_nrn_done) state_nxt = S_NEXT;
`endif
      S_NEXT:   state_nxt = last_step ? S_DONE : S_FILL;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign stage_clr = !(state == S_FILL || state == S_REPLAY);

  pb_spike_stage #(
    .DEPTH (N_BEAT)
  ) u_stage (
    .clk     (clk),
    .reset   (reset),
    .clr     (stage_clr),
    .wr_en   (wr_en),
    .wr_data (bus.i_src_spike),
    .rd_en   (rd_en),
    .rd_data (stage_data),
    .last    (stage_last)
  );

  assign bus.o_src_ready   = src_ready;
  assign bus.o_pb_init     = cmd.init;
  assign bus.o_pb_b_run    = cmd.b_run;
  assign bus.o_pb_stdp_run = cmd.stdp_run;
  assign bus.o_pb_valid    = pb_valid;
  assign bus.o_pb_spike    = pb_valid ? stage_data : '0;
  assign bus.o_nrn_run     = nrn_run;

  assign o_busy = (state != S_IDLE) && (state != S_DONE);
  assign o_done = (state == S_DONE);
  assign o_step = step;

endmodule

// File: tb/tb_pb_step_scheduler.sv
// Randomised bench for pb_step_scheduler with a behavioural environment
// (source, preBuffer, neuron stage) and an event-order reference model.
module tb_pb_step_scheduler;

  localparam int EV_INIT = 1;
  localparam int EV_BRUN = 2;
  localparam int EV_NRN  = 3;
  localparam int EV_STDP = 4;
  localparam int EV_DONE = 5;
`ifdef PB_SCHED_STDP_EN
  localparam bit STDP_EN = 1'b1;
`else
  localparam bit STDP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_start = 1'b0;
  logic       i_learn = 1'b0;
  logic [7:0] i_num_step = 8'd0;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_step;

  pb_step_scheduler_if bus_if ();

  pb_step_scheduler #(
    .N_BEAT (144),
    .STEP_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_num_step (i_num_step),
    .i_learn    (i_learn),
    .bus        (bus_if),
    .o_busy     (o_busy),
    .o_step     (o_step),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         ev_q[$];
  int         exp_q[$];
  logic [7:0] step_q[$];
  logic [3:0] sent_q[$];
  int         obs_rep_bad = 0;
  int         obs_rep_beats = 0;
  int         obs_early = 0;
  logic [3:0] obs_rep_first = 4'd0;
  logic [3:0] obs_rep_last = 4'd0;
  int         src_mode = 0;

  // Environment: drives source and done pulses at negedge, records observations.
  initial begin : env
    int   pb_cnt;
    int   nrn_cnt;
    int   run_len;
    int   src_beat;
    int   cyc;
    bit   prev_ready;
    bit   prev_brun;
    bit   stdp_wait;
    logic [7:0] prev_step;
    logic [3:0] exp_spk;
    pb_cnt = 0; nrn_cnt = 0; run_len = 0; src_beat = 0; cyc = 0;
    prev_ready = 0; prev_brun = 0; stdp_wait = 0; prev_step = 8'd0;
    bus_if.i_src_valid = 1'b0;
    bus_if.i_src_spike = 4'd0;
    bus_if.i_pb_done   = 1'b0;
    bus_if.i_nrn_done  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      bus_if.i_pb_done  = 1'b0;
      bus_if.i_nrn_done = 1'b0;
      if (reset) begin
        pb_cnt = 0; nrn_cnt = 0; run_len = 0; src_beat = 0;
        prev_ready = 0; prev_brun = 0; stdp_wait = 0; prev_step = 8'd0;
        sent_q.delete();
        bus_if.i_src_valid = 1'b0;
        continue;
      end
      if (bus_if.i_src_valid && prev_ready) begin
        sent_q.push_back(bus_if.i_src_spike);
        src_beat++;
        bus_if.i_src_valid = 1'b0;
      end
      if (!bus_if.i_src_valid) begin
        if (src_mode == 0 || (src_mode == 1 && cyc % 3 == 0) ||
            (src_mode == 2 && $urandom_range(0, 1) == 1)) begin
          bus_if.i_src_valid = 1'b1;
          bus_if.i_src_spike = (src_mode == 2) ? 4'($urandom_range(0, 15)) : 4'(src_beat);
        end
      end
      prev_ready = bus_if.o_src_ready;
      if (pb_cnt != 0) begin
        pb_cnt--;
        if (pb_cnt == 0) begin
          bus_if.i_pb_done = 1'b1;
          stdp_wait = 0;
        end
      end
      if (nrn_cnt != 0) begin
        nrn_cnt--;
        if (nrn_cnt == 0) bus_if.i_nrn_done = 1'b1;
      end
      if (pb_cnt == 0 && nrn_cnt == 0 && bus_if.o_src_ready && $urandom_range(0, 15) == 0) begin
        bus_if.i_pb_done  = 1'b1;
        bus_if.i_nrn_done = 1'b1;
      end
      if (o_step !== prev_step && stdp_wait) obs_early++;
      prev_step = o_step;
      if (bus_if.o_pb_init) begin
        ev_q.push_back(EV_INIT);
        pb_cnt = $urandom_range(1, 4);
      end
      if (bus_if.o_pb_b_run) begin
        ev_q.push_back(EV_BRUN);
        step_q.push_back(o_step);
        if (sent_q.size() != 144) obs_rep_bad++;
        pb_cnt = 145 + $urandom_range(0, 5);
      end
      if (bus_if.o_pb_stdp_run) begin
        ev_q.push_back(EV_STDP);
        pb_cnt = $urandom_range(1, 4);
        stdp_wait = 1;
      end
      if (bus_if.o_nrn_run) begin
        ev_q.push_back(EV_NRN);
        nrn_cnt = $urandom_range(1, 4);
      end
      if (o_done) begin
        ev_q.push_back(EV_DONE);
        if (stdp_wait) obs_early++;
      end
      if (bus_if.o_pb_valid) begin
        if (run_len == 0 && !prev_brun) obs_rep_bad++;
        if (sent_q.size() == 0) obs_rep_bad++;
        else begin
          exp_spk = sent_q.pop_front();
          if (bus_if.o_pb_spike !== exp_spk) obs_rep_bad++;
        end
        if (run_len == 0) obs_rep_first = bus_if.o_pb_spike;
        obs_rep_last = bus_if.o_pb_spike;
        run_len++;
        obs_rep_beats++;
      end else if (run_len != 0) begin
        if (run_len != 144) obs_rep_bad++;
        run_len = 0;
      end
      prev_brun = bus_if.o_pb_b_run;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    ev_q.delete();
    step_q.delete();
    obs_rep_bad = 0;
    obs_rep_beats = 0;
    obs_early = 0;
  endtask

  // Expected pulse order from the step rules: INIT, per step BRUN NRN [STDP], DONE.
  task automatic build_expect(input int n, input bit learn);
    int ne;
    ne = (n == 0) ? 1 : n;
    exp_q.delete();
    exp_q.push_back(EV_INIT);
    for (int s = 0; s < ne; s++) begin
      exp_q.push_back(EV_BRUN);
      exp_q.push_back(EV_NRN);
      if (learn && STDP_EN) exp_q.push_back(EV_STDP);
    end
    exp_q.push_back(EV_DONE);
  endtask

  task automatic start_run(input int n, input bit learn);
    tick();
    i_start = 1'b1;
    i_num_step = 8'(n);
    i_learn = learn;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    vectors++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_status: busy=%b done=%b, required 0 0", o_busy, o_done);
    end
    vectors++;
    if (o_step !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_step: got %0d, required 0", o_step);
    end
    vectors++;
    if ({bus_if.o_src_ready, bus_if.o_pb_init, bus_if.o_pb_b_run, bus_if.o_pb_stdp_run,
         bus_if.o_pb_valid, bus_if.o_pb_spike, bus_if.o_nrn_run} !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_bus: outputs not all zero, required 0");
    end
    i_start = 1'b1;
    tick();
    tick();
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_start_held: busy=%b, required 0", o_busy);
    end
    i_start = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_step_run(input string name, input int n, input bit learn,
                               input int mode, input bit chk_pattern);
    int ne;
    int cyc;
    bit bad;
    ne = (n == 0) ? 1 : n;
    src_mode = mode;
    clear_obs();
    build_expect(n, learn);
    start_run(n, learn);
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 2000 * ne) begin
      tick();
      cyc++;
    end
    vectors++;
    if (o_done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s done_timeout: no o_done after %0d cycles, required one", name, cyc);
    end
    vectors++;
    if ({o_busy, o_step} !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL %s done_cycle: busy=%b step=%0d, required 0 0", name, o_busy, o_step);
    end
    bad = (ev_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (ev_q[i] != exp_q[i]) bad = 1;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL %s events: got %0d pulses in wrong order/count, required %0d", name, ev_q.size(), exp_q.size());
    end
    vectors++;
    if (obs_rep_bad !== 0) begin
      miscompares++;
      $display("[TB] FAIL %s replay: %0d bad beats/runs, required 0", name, obs_rep_bad);
    end
    vectors++;
    if (obs_rep_beats !== 144 * ne) begin
      miscompares++;
      $display("[TB] FAIL %s replay_beats: got %0d, required %0d", name, obs_rep_beats, 144 * ne);
    end
    bad = (step_q.size() != ne);
    if (!bad) foreach (step_q[i]) if (step_q[i] != 8'(i)) bad = 1;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL %s step_seq: %0d kicks with wrong step index, required 0..%0d", name, step_q.size(), ne - 1);
    end
    vectors++;
    if (obs_early !== 0) begin
      miscompares++;
      $display("[TB] FAIL %s stdp_wait: step advanced %0d times before pb_done, required 0", name, obs_early);
    end
    if (chk_pattern) begin
      vectors++;
      if (obs_rep_first !== 4'd0 || obs_rep_last !== 4'd15) begin
        miscompares++;
        $display("[TB] FAIL %s pattern: first=%0d last=%0d, required 0 15", name, obs_rep_first, obs_rep_last);
      end
    end
    tick();
  endtask

  task automatic test_ignored_start();
    int cyc;
    bit bad;
    src_mode = 0;
    clear_obs();
    build_expect(1, 1'b0);
    start_run(1, 1'b0);
    cyc = 0;
    while (bus_if.o_pb_valid !== 1'b1 && cyc < 1000) begin
      tick();
      cyc++;
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
    end
    vectors++;
    if (o_done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ign_done_timeout: no o_done, required one");
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ign_done_start: busy=%b after start in done cycle, required 0", o_busy);
    end
    bad = (ev_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (ev_q[i] != exp_q[i]) bad = 1;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL ign_events: got %0d pulses, required %0d in order", ev_q.size(), exp_q.size());
    end
    test_step_run("restart", 1, 1'b0, 2, 1'b0);
  endtask

  task automatic test_reset_mid_replay();
    int cyc;
    int nval;
    src_mode = 0;
    clear_obs();
    start_run(2, 1'b0);
    cyc = 0;
    nval = 0;
    while (nval < 144 + 71 && cyc < 3000) begin
      tick();
      cyc++;
      if (bus_if.o_pb_valid === 1'b1) nval++;
    end
    vectors++;
    if (o_step !== 8'd1 || bus_if.o_pb_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_replay_reach: step=%0d valid=%b, required 1 1", o_step, bus_if.o_pb_valid);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if ({o_busy, o_done, o_step, bus_if.o_src_ready, bus_if.o_pb_init, bus_if.o_pb_b_run,
         bus_if.o_pb_stdp_run, bus_if.o_pb_valid, bus_if.o_pb_spike, bus_if.o_nrn_run} !== 20'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_replay_reset: busy=%b step=%0d valid=%b, required all outputs 0",
               o_busy, o_step, bus_if.o_pb_valid);
    end
    reset = 1'b0;
    tick();
    test_step_run("after_reset", 1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    $display("[TB] pb_step_scheduler bench, stdp build=%0d", STDP_EN);
    test_reset();
    test_step_run("single", 1, 1'b0, 0, 1'b1);
    test_step_run("three_step", 3, 1'b0, 1, 1'b0);
    test_step_run("zero_step", 0, 1'b0, 2, 1'b0);
    test_ignored_start();
    test_reset_mid_replay();
    test_step_run("learn1", 2, 1'b1, 2, 1'b0);
    test_step_run("learn0", 2, 1'b0, 1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
